score_display_scanner: RTL

//   Parametrised N-digit seven-segment scoreboard driver. Accepts a binary run total and wicket

---
 rtl/score_display_pkg.sv | 48 ++++
 rtl/bin_to_bcd_seq.sv | 90 +++++++++
 rtl/score_display_scanner.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/score_display_pkg.sv
// Shared encodings for the scoreboard driver: active-low segment patterns {g..a},
// display mode and converter state enums, plus small constant helpers.
package score_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_I     = 7'h4F;
  localparam logic [6:0] SEG_O     = 7'h23;
  localparam logic [6:0] SEG_P     = 7'h0C;

  typedef enum logic [1:0] {
    MODE_SCORE,
    MODE_INNINGS,
    MODE_GAMEOVER
  } mode_e;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_COMMIT
  } conv_state_e;

  function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter, one bit per cycle, saturating to all nines
// when the input does not fit in NUM_BCD decimal digits.
//
//   state       | meaning
//   CONV_IDLE   | waiting for start; bcd holds last result
//   CONV_SHIFT  | BIN_W add-3-then-shift steps, bit_cnt counts down to 0
//   CONV_COMMIT | one cycle with done=1 and bcd valid
module bin_to_bcd_seq
  import score_display_pkg::*;
#(
  parameter int BIN_W   = 8,
  parameter int NUM_BCD = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [BIN_W-1:0]       bin,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_BCD*4-1:0]   bcd
);

  localparam int          BCD_W   = NUM_BCD * 4;
  localparam int          CNT_W   = $clog2(BIN_W);
  localparam logic [63:0] MAX_VAL = pow10(NUM_BCD) - 64'd1;

  conv_state_e        state;
  logic [BIN_W-1:0]   bin_sr;
  logic [BCD_W-1:0]   bcd_sr;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_next;
  logic [CNT_W-1:0]   bit_cnt;
  logic               sat_q;

  always_comb begin
    bcd_adj = bcd_sr;
    for (int j = 0; j < NUM_BCD; j++) begin
      if (bcd_sr[4*j +: 4] >= 4'd5) bcd_adj[4*j +: 4] = bcd_sr[4*j +: 4] + 4'd3;
    end
    bcd_next = (bcd_adj << 1) | BCD_W'(bin_sr[BIN_W-1]);
  end

  // Digits above NUM_BCD fall off the top of bcd_sr; harmless because any value
  // that needs them is saturated anyway.
  assign bcd = sat_q ? {NUM_BCD{4'd9}} : bcd_sr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CONV_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_sr  <= '0;
      bcd_sr  <= '0;
      bit_cnt <= '0;
      sat_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        CONV_IDLE: begin
          if (start) begin
            state   <= CONV_SHIFT;
            busy    <= 1'b1;
            bin_sr  <= bin;
            bcd_sr  <= '0;
            bit_cnt <= CNT_W'(BIN_W - 1);
            sat_q   <= (64'(bin) > MAX_VAL);
          end
        end
        CONV_SHIFT: begin
          bcd_sr  <= bcd_next;
          bin_sr  <= bin_sr << 1;
          bit_cnt <= bit_cnt - 1'b1;
          if (bit_cnt == '0) begin
            state <= CONV_COMMIT;
            done  <= 1'b1;
          end
        end
        CONV_COMMIT: begin
          state <= CONV_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= CONV_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/score_display_scanner.sv
// Seven-segment scoreboard driver: latches converted runs/wickets on commit and
// multiplexes digits onto shared active-low cathodes with message modes.
module score_display_scanner
  import score_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 8,
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int BLANK_LZ   = 1
) (
  input  logic                  clk_fpga,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [BIN_W-1:0]      runs,
  input  logic [3:0]            wickets,
  input  logic                  inning_over,
  input  logic                  game_over,
  input  logic                  winner,
  output logic                  busy,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int NUM_BCD  = NUM_DIGITS - 1;
  localparam int TICK_DIV = CLK_HZ / REFRESH_HZ;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W    = $clog2(NUM_DIGITS);

  logic [PRE_W-1:0]       presc;
  logic [IDX_W-1:0]       idx;
  logic                   scan_tick;
  logic                   conv_done;
  logic [NUM_BCD*4-1:0]   conv_bcd;
  logic [3:0]             wick_cap;
  logic [NUM_BCD*4-1:0]   run_bcd;
  logic [3:0]             wick_q;
  logic [NUM_BCD-1:0]     nz_from;
  mode_e                  mode;
  logic [6:0]             cur_seg;
  logic                   cur_dp;
  logic [3:0]             dig;

  bin_to_bcd_seq #(
    .BIN_W   (BIN_W),
    .NUM_BCD (NUM_BCD)
  ) u_conv (
    .clk   (clk_fpga),
    .rst_n (rst_n),
    .start (load & ~busy),
    .bin   (runs),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Wickets ride alongside the conversion so both fields change on the same cycle.
  always_ff @(posedge clk_fpga) begin
    if (!rst_n) begin
      wick_cap <= '0;
      run_bcd  <= '0;
      wick_q   <= '0;
    end else begin
      if (load && !busy) wick_cap <= wickets;
      if (conv_done) begin
        run_bcd <= conv_bcd;
        wick_q  <= wick_cap;
      end
    end
  end

  assign scan_tick = (presc == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge clk_fpga) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (scan_tick) begin
      presc <= '0;
      idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_comb begin
    if (game_over)        mode = MODE_GAMEOVER;
    else if (inning_over) mode = MODE_INNINGS;
    else                  mode = MODE_SCORE;
  end

  // nz_from[j]: some run digit at position j or above is non-zero.
  always_comb begin
    logic acc;
    acc     = 1'b0;
    nz_from = '0;
    for (int j = NUM_BCD - 1; j >= 0; j--) begin
      acc        = acc | (run_bcd[4*j +: 4] != 4'd0);
      nz_from[j] = acc;
    end
  end

  always_comb begin
    cur_seg = SEG_BLANK;
    cur_dp  = 1'b1;
    dig     = 4'd0;
    unique case (mode)
      MODE_GAMEOVER: begin
        if (idx == IDX_W'(1))      cur_seg = SEG_P;
        else if (idx == IDX_W'(0)) cur_seg = seg_of_digit(winner ? 4'd2 : 4'd1);
      end
      MODE_INNINGS: begin
        if (idx == IDX_W'(1))      cur_seg = SEG_I;
        else if (idx == IDX_W'(0)) cur_seg = SEG_O;
      end
      default: begin
        if (idx == IDX_W'(0)) begin
          cur_seg = (wick_q >= 4'd10) ? SEG_DASH : seg_of_digit(wick_q);
        end
        for (int k = 1; k < NUM_DIGITS; k++) begin
          if (idx == IDX_W'(k)) begin
            dig = run_bcd[4*(k-1) +: 4];
            if (BLANK_LZ != 0 && k > 1 && !nz_from[k-1]) cur_seg = SEG_BLANK;
            else                                          cur_seg = seg_of_digit(dig);
            cur_dp = (k != 1);
          end
        end
      end
    endcase
  end

  // Anode, cathodes and dp leave the same register stage so they never disagree.
  always_ff @(posedge clk_fpga) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(NUM_DIGITS'(1) << idx);
      seg <= cur_seg;
      dp  <= cur_dp;
    end
  end

endmodule
